// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose: shares the single register-file write port between NUM_REQ
// writeback sources (ALU pipe, load/store unit, multiply/divide unit).
// A combinational round-robin arbiter picks one valid requester per cycle.
// The accepted write is registered once and then driven onto the regfile
// write port, so a write appears on the port one cycle after it is accepted.
//
// Ports:
//   clk                  - clock; all state updates on the rising edge
//   rst                  - synchronous, active-low reset
//   flush                - exception/eret flush; blocks the accept and
//                          suppresses the next write enable
//   req_valid[NUM_REQ]   - per-requester write request
//   req_addr             - packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data             - packed data, requester i at [i*DATA_W +: DATA_W]
//   req_ready[NUM_REQ]   - one-hot grant; handshake = req_valid & req_ready
//   regfile_write_enable - regfile write enable
//   regfile_write_addr   - regfile write address
//   regfile_write_data   - regfile write data
//   rr_ptr_o[3]          - current round-robin pointer (debug only)
//
// Build option:
//   WB_ARB_FIXED_PRIO_EN - when defined, fixed priority (requester 0
//   highest); the round-robin pointer is removed and rr_ptr_o reads 0.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        regfile_write_enable,
    output logic [ADDR_W-1:0]           regfile_write_addr,
    output logic [DATA_W-1:0]           regfile_write_data,
    output logic [2:0]                  rr_ptr_o
);

    logic [NUM_REQ-1:0] grant;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;
    logic               found;
    logic               accept;

`ifdef WB_ARB_FIXED_PRIO_EN

    // Lowest index wins; no pointer state at all.
    always_comb begin
        grant    = '0;
        win_addr = '0;
        win_data = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rr_ptr_o = 3'd0;

`else

    localparam logic [2:0] LAST_IDX = 3'(NUM_REQ - 1);

    logic [2:0] rr_ptr;
    logic [2:0] win_idx;
    logic [2:0] next_ptr;

    // Rotating scan done as two ascending passes: first the requesters at or
    // above the pointer, then the ones below it (the wrapped part).
    always_comb begin
        grant    = '0;
        win_addr = '0;
        win_data = '0;
        win_idx  = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (3'(i) >= rr_ptr)) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                win_idx  = 3'(i);
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (3'(i) < rr_ptr)) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                win_idx  = 3'(i);
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign next_ptr = (win_idx == LAST_IDX) ? 3'd0 : win_idx + 3'd1;

    // Pointer moves past the winner only on a completed handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr <= 3'd0;
        end else if (accept) begin
            rr_ptr <= next_ptr;
        end
    end

    assign rr_ptr_o = rr_ptr;

`endif

    // Reset and flush both hide the grant so no handshake can complete.
    assign req_ready = (rst && !flush) ? grant : '0;
    assign accept    = |req_ready;

    // Output stage: a write to register 0 is consumed but never enabled.
    // Address/data only follow accepted writes and otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regfile_write_enable <= 1'b0;
            regfile_write_addr   <= '0;
            regfile_write_data   <= '0;
        end else begin
            regfile_write_enable <= accept && (win_addr != '0);
            if (accept) begin
                regfile_write_addr <= win_addr;
                regfile_write_data <= win_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Purpose: directed self-checking bench for regfile_wb_arbiter with the
// default parameters (3 requesters, 5-bit address, 32-bit data).
// Inputs change 1 time unit after a rising edge; outputs are checked a
// further time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;

    logic                       clk;
    logic                       rst;
    logic                       flush;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       regfile_write_enable;
    logic [ADDR_W-1:0]          regfile_write_addr;
    logic [DATA_W-1:0]          regfile_write_data;
    logic [2:0]                 rr_ptr_o;

    int tests_run;
    int tests_failed;

    regfile_wb_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .req_valid           (req_valid),
        .req_addr            (req_addr),
        .req_data            (req_data),
        .req_ready           (req_ready),
        .regfile_write_enable(regfile_write_enable),
        .regfile_write_addr  (regfile_write_addr),
        .regfile_write_data  (regfile_write_data),
        .rr_ptr_o            (rr_ptr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic set_req(input int idx, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data);
        req_addr[idx*ADDR_W +: ADDR_W] = addr;
        req_data[idx*DATA_W +: DATA_W] = data;
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Apply request inputs, then let combinational logic settle.
    task automatic apply_stimulus(input logic [NUM_REQ-1:0] valid, input logic flush_in);
        req_valid = valid;
        flush     = flush_in;
        #1;
    endtask

    logic [2:0]  rot_ready [6];
    logic [4:0]  rot_addr  [6];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        flush        = 1'b0;
        req_valid    = '0;
        req_addr     = '0;
        req_data     = '0;

        // Reset held two cycles with all requesters valid
        set_req(0, 5'd1, 32'h1111_0001);
        set_req(1, 5'd2, 32'h2222_0002);
        set_req(2, 5'd3, 32'h3333_0003);
        req_valid = 3'b111;
        next_cycle();
        next_cycle();
        check_output("reset_ready", 64'(req_ready), 64'h0);
        check_output("reset_we",    64'(regfile_write_enable), 64'h0);
        check_output("reset_addr",  64'(regfile_write_addr), 64'h0);
        check_output("reset_data",  64'(regfile_write_data), 64'h0);
        check_output("reset_ptr",   64'(rr_ptr_o), 64'h0);

`ifdef WB_ARB_FIXED_PRIO_EN
        // Fixed priority: requester 0 wins every cycle
        rst = 1'b1;
        apply_stimulus(3'b111, 1'b0);
        for (int c = 0; c < 4; c++) begin
            check_output("fixed_ready", 64'(req_ready), 64'h1);
            check_output("fixed_ptr",   64'(rr_ptr_o), 64'h0);
            next_cycle();
            check_output("fixed_we",    64'(regfile_write_enable), 64'h1);
            check_output("fixed_addr",  64'(regfile_write_addr), 64'h1);
        end
`else
        // Single request from requester 1
        rst = 1'b1;
        apply_stimulus(3'b000, 1'b0);
        check_output("idle_ready", 64'(req_ready), 64'h0);
        set_req(1, 5'd8, 32'hDEAD_BEEF);
        apply_stimulus(3'b010, 1'b0);
        check_output("single_ready", 64'(req_ready), 64'h2);
        next_cycle();
        check_output("single_we",   64'(regfile_write_enable), 64'h1);
        check_output("single_addr", 64'(regfile_write_addr), 64'h8);
        check_output("single_data", 64'(regfile_write_data), 64'hDEAD_BEEF);
        check_output("single_ptr",  64'(rr_ptr_o), 64'h2);
        apply_stimulus(3'b000, 1'b0);
        next_cycle();
        check_output("single_we_off", 64'(regfile_write_enable), 64'h0);
        check_output("single_addr_hold", 64'(regfile_write_addr), 64'h8);

        // Re-reset so the rotation starts from pointer 0
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        set_req(0, 5'd1, 32'h1111_0001);
        set_req(1, 5'd2, 32'h2222_0002);
        set_req(2, 5'd3, 32'h3333_0003);
        rot_ready = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rot_addr  = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
        apply_stimulus(3'b111, 1'b0);
        for (int c = 0; c < 6; c++) begin
            check_output("rot_ready", 64'(req_ready), 64'(rot_ready[c]));
            next_cycle();
            #1;
            check_output("rot_we",   64'(regfile_write_enable), 64'h1);
            check_output("rot_addr", 64'(regfile_write_addr), 64'(rot_addr[c]));
        end

        // Zero-address write: consumed, pointer advances, no enable
        set_req(0, 5'd0, 32'h0000_1234);
        apply_stimulus(3'b001, 1'b0);
        check_output("zero_ready", 64'(req_ready), 64'h1);
        next_cycle();
        check_output("zero_we",  64'(regfile_write_enable), 64'h0);
        check_output("zero_ptr", 64'(rr_ptr_o), 64'h1);

        // Flush blocks the accept for one cycle, then the grant proceeds
        set_req(2, 5'd9, 32'hCAFE_F00D);
        apply_stimulus(3'b100, 1'b1);
        check_output("flush_ready", 64'(req_ready), 64'h0);
        next_cycle();
        check_output("flush_we",  64'(regfile_write_enable), 64'h0);
        check_output("flush_ptr", 64'(rr_ptr_o), 64'h1);
        apply_stimulus(3'b100, 1'b0);
        check_output("postflush_ready", 64'(req_ready), 64'h4);
        next_cycle();
        check_output("postflush_we",   64'(regfile_write_enable), 64'h1);
        check_output("postflush_addr", 64'(regfile_write_addr), 64'h9);
        check_output("postflush_data", 64'(regfile_write_data), 64'hCAFE_F00D);
        check_output("postflush_ptr",  64'(rr_ptr_o), 64'h0);

        // Pointer 0 skips idle requester 0, then wraps from 2 back to 0
        set_req(1, 5'd4, 32'h4444_0004);
        set_req(2, 5'd5, 32'h5555_0005);
        apply_stimulus(3'b110, 1'b0);
        check_output("skip_ready", 64'(req_ready), 64'h2);
        next_cycle();
        check_output("skip_addr", 64'(regfile_write_addr), 64'h4);
        check_output("skip_ptr",  64'(rr_ptr_o), 64'h2);
        set_req(0, 5'd6, 32'h6666_0006);
        apply_stimulus(3'b011, 1'b0);
        check_output("wrap_ready", 64'(req_ready), 64'h1);
        next_cycle();
        check_output("wrap_addr", 64'(regfile_write_addr), 64'h6);
        check_output("wrap_ptr",  64'(rr_ptr_o), 64'h1);

        // Reset together with flush and a pending request: reset wins
        set_req(0, 5'd7, 32'h7777_0007);
        rst = 1'b0;
        apply_stimulus(3'b001, 1'b1);
        check_output("rstmid_ready", 64'(req_ready), 64'h0);
        next_cycle();
        check_output("rstmid_we",   64'(regfile_write_enable), 64'h0);
        check_output("rstmid_addr", 64'(regfile_write_addr), 64'h0);
        check_output("rstmid_ptr",  64'(rr_ptr_o), 64'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: observed no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
